// File: rtl/divvy_pkg.sv
// Shared types, widths and the branch-target table for the divvy 8-bit load/store core.
package divvy_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int DATA_WIDTH  = 8;
    localparam int INSTR_WIDTH = 9;
    localparam int REG_COUNT   = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_LW   = 3'b100,
        OP_SW   = 3'b101,
        OP_ADDI = 3'b110,
        OP_MISC = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        MISC_SHL  = 3'b000,
        MISC_SHR  = 3'b001,
        MISC_BZ   = 3'b010,
        MISC_BNZ  = 3'b011,
        MISC_JMP  = 3'b100,
        MISC_NOP0 = 3'b101,
        MISC_NOP1 = 3'b110,
        MISC_HALT = 3'b111
    } misc_e;

    // Absolute branch targets, indexed by the b field of BZ/BNZ/JMP.
    localparam logic [PC_WIDTH-1:0] BRANCH_LUT [REG_COUNT] = '{
        10'd23, 10'd8, 10'd67, 10'd72, 10'd76, 10'd100, 10'd200, 10'd1023
    };

    function automatic opcode_e instrOp(input logic [INSTR_WIDTH-1:0] instr);
        return opcode_e'(instr[8:6]);
    endfunction

    function automatic logic [2:0] instrA(input logic [INSTR_WIDTH-1:0] instr);
        return instr[5:3];
    endfunction

    function automatic logic [2:0] instrB(input logic [INSTR_WIDTH-1:0] instr);
        return instr[2:0];
    endfunction

endpackage

// File: rtl/divvy_alu.sv
// Combinational ALU: arithmetic/logic ops, ADDI with 3-bit signed immediate, and 1-bit shifts.
module divvy_alu
    import divvy_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH
) (
    input  opcode_e           op,
    input  misc_e             subOp,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic [2:0]        imm,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Shifts operate on the b-register operand; other ops use a op b.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = opA + opB;
            OP_SUB:  result = opA - opB;
            OP_AND:  result = opA & opB;
            OP_XOR:  result = opA ^ opB;
            OP_ADDI: result = opA + {{(DATA_W-3){imm[2]}}, imm};
            OP_MISC: begin
                if (subOp == MISC_SHR)
                    result = {1'b0, opB[DATA_W-1:1]};
                else
                    result = {opB[DATA_W-2:0], 1'b0};
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/divvy_cpu_top.sv
// Single-cycle divvy core: ROM, register file, data memory, PC and START/DONE program sequencing.
module divvy_cpu_top
    import divvy_pkg::*;
#(
    parameter int    PC_W       = PC_WIDTH,
    parameter int    DATA_W     = DATA_WIDTH,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_FILE  = "machine_code.txt"
) (
    input  logic CLK,
    input  logic START,
    output logic DONE
);

    logic [INSTR_WIDTH-1:0] instrMem [2**PC_W];
    logic [DATA_W-1:0]      regFile  [REG_COUNT];
    logic [DATA_W-1:0]      dataMem  [DMEM_DEPTH];

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] resumePc = '0;
    logic            running  = 1'b0;
    logic            done     = 1'b0;
    logic            halted;
    logic            zeroFlag;

    logic [INSTR_WIDTH-1:0] instr;
    opcode_e                op;
    misc_e                  subOp;
    logic [2:0]             fieldA;
    logic [2:0]             fieldB;
    logic [DATA_W-1:0]      regA;
    logic [DATA_W-1:0]      regB;
    logic [DATA_W-1:0]      memRead;
    logic [DATA_W-1:0]      aluResult;
    logic                   aluZero;
    logic [PC_W-1:0]        branchTarget;

    assign instr        = instrMem[pc];
    assign op           = instrOp(instr);
    assign fieldA       = instrA(instr);
    assign fieldB       = instrB(instr);
    assign subOp        = misc_e'(fieldA);
    assign regA         = regFile[fieldA];
    assign regB         = regFile[fieldB];
    assign memRead      = dataMem[regB];
    assign branchTarget = PC_W'(BRANCH_LUT[fieldB]);
    assign DONE         = done;

    divvy_alu #(.DATA_W(DATA_W)) alu (
        .op    (op),
        .subOp (subOp),
        .opA   (regA),
        .opB   (regB),
        .imm   (fieldB),
        .result(aluResult),
        .zero  (aluZero)
    );

    logic              regWe;
    logic [2:0]        regWaddr;
    logic [DATA_W-1:0] regWdata;
    logic              memWe;
    logic              zeroWe;
    logic              haltNow;
    logic [PC_W-1:0]   nextPc;

    always_comb begin
        regWe    = 1'b0;
        regWaddr = fieldA;
        regWdata = aluResult;
        memWe    = 1'b0;
        zeroWe   = 1'b0;
        haltNow  = 1'b0;
        nextPc   = pc + PC_W'(1);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_ADDI: begin
                regWe  = 1'b1;
                zeroWe = 1'b1;
            end
            OP_LW: begin
                regWe    = 1'b1;
                regWdata = memRead;
            end
            OP_SW: memWe = 1'b1;
            OP_MISC: begin
                case (subOp)
                    MISC_SHL, MISC_SHR: begin
                        regWe    = 1'b1;
                        regWaddr = fieldB;
                        zeroWe   = 1'b1;
                    end
                    MISC_BZ:  if (zeroFlag)  nextPc = branchTarget;
                    MISC_BNZ: if (!zeroFlag) nextPc = branchTarget;
                    MISC_JMP: nextPc = branchTarget;
                    MISC_HALT: begin
                        haltNow = 1'b1;
                        nextPc  = pc;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // START relaunches at the instruction after the last HALT; it never moves resumePc.
    always_ff @(posedge CLK) begin
        if (START) begin
            pc       <= resumePc;
            done     <= 1'b0;
            halted   <= 1'b0;
            zeroFlag <= 1'b0;
            running  <= 1'b1;
        end else if (running && !halted) begin
            pc <= nextPc;
            if (zeroWe)
                zeroFlag <= aluZero;
            if (haltNow) begin
                halted   <= 1'b1;
                done     <= 1'b1;
                resumePc <= pc + PC_W'(1);
            end
        end
    end

    // Registers and data memory persist across START so programs can hand data on.
    always_ff @(posedge CLK) begin
        if (!START && running && !halted) begin
            if (regWe)
                regFile[regWaddr] <= regWdata;
            if (memWe)
                dataMem[regB] <= regA;
        end
    end

endmodule

// File: tb/tb_divvy_cpu_top.sv
// Scoreboard bench for divvy_cpu_top: programs are executed by an ISA-level model and results queued for a monitor.
module tb_divvy_cpu_top;

    localparam int ROM_DEPTH     = 1024;
    localparam int RAND_PROGRAMS = 12;
    localparam int CYCLE_BUDGET  = 2000;
    localparam int TARGETS [8]   = '{23, 8, 67, 72, 76, 100, 200, 1023};

    logic CLK   = 1'b0;
    logic START = 1'b0;
    logic DONE;

    int checks       = 0;
    int failures     = 0;
    int launches     = 0;
    int checkedCount = 0;

    divvy_cpu_top #(
        .PC_W      (10),
        .DATA_W    (8),
        .DMEM_DEPTH(256),
        .IMEM_FILE ("")
    ) dut (
        .CLK  (CLK),
        .START(START),
        .DONE (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int            cycles;
        logic [9:0]    haltPc;
        logic          zero;
        logic [63:0]   regs;
        logic [2047:0] mem;
    } expect_t;

    expect_t expectQ[$];

    int rom [ROM_DEPTH];
    int romFill = 0;
    int mRegs [8];
    int mMem [256];
    int mZ      = 0;
    int mPc     = 0;
    int mResume = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void emit(input int op, input int a, input int b);
        rom[romFill] = op * 64 + a * 8 + b;
        romFill++;
    endfunction

    // One instruction of the architectural model; returns 1 when it was HALT.
    function automatic bit modelStep();
        int instr = rom[mPc];
        int op    = instr / 64;
        int a     = (instr / 8) % 8;
        int b     = instr % 8;
        int next  = (mPc + 1) % ROM_DEPTH;
        int imm   = (b >= 4) ? b - 8 : b;
        bit halt  = 1'b0;
        case (op)
            0: mRegs[a] = (mRegs[a] + mRegs[b]) % 256;
            1: mRegs[a] = (mRegs[a] - mRegs[b] + 256) % 256;
            2: mRegs[a] = mRegs[a] & mRegs[b];
            3: mRegs[a] = mRegs[a] ^ mRegs[b];
            4: mRegs[a] = mMem[mRegs[b]];
            5: mMem[mRegs[b]] = mRegs[a];
            6: mRegs[a] = (mRegs[a] + imm + 256) % 256;
            default: begin
                case (a)
                    0: mRegs[b] = (mRegs[b] * 2) % 256;
                    1: mRegs[b] = mRegs[b] / 2;
                    2: if (mZ != 0) next = TARGETS[b];
                    3: if (mZ == 0) next = TARGETS[b];
                    4: next = TARGETS[b];
                    7: begin
                        halt = 1'b1;
                        next = mPc;
                    end
                    default: ;
                endcase
            end
        endcase
        if (op <= 3 || op == 6)
            mZ = (mRegs[a] == 0) ? 1 : 0;
        else if (op == 7 && a <= 1)
            mZ = (mRegs[b] == 0) ? 1 : 0;
        mPc = next;
        return halt;
    endfunction

    function automatic expect_t runModel();
        expect_t e;
        bit      halt = 1'b0;
        int      n    = 0;
        mPc = mResume;
        mZ  = 0;
        while (!halt && n < CYCLE_BUDGET) begin
            halt = modelStep();
            n++;
        end
        mResume  = (mPc + 1) % ROM_DEPTH;
        e.cycles = n;
        e.haltPc = 10'(mPc);
        e.zero   = (mZ != 0);
        for (int i = 0; i < 8; i++)   e.regs[i*8 +: 8] = 8'(mRegs[i]);
        for (int i = 0; i < 256; i++) e.mem[i*8 +: 8]  = 8'(mMem[i]);
        return e;
    endfunction

    function automatic void modelPartial(input int n);
        mPc = mResume;
        mZ  = 0;
        for (int i = 0; i < n; i++) void'(modelStep());
    endfunction

    function automatic void buildRom();
        int op;
        int a;
        int len;
        for (int i = 0; i < 8; i++) emit(3, i, i);
        emit(5, 0, 1); emit(6, 1, 1); emit(7, 3, 1); emit(7, 7, 0);
        emit(6, 1, 3); emit(6, 1, 3); emit(0, 2, 1); emit(7, 7, 0);
        emit(6, 3, 2); emit(6, 4, 7); emit(5, 4, 3); emit(4, 5, 3); emit(7, 7, 0);
        emit(3, 1, 1); emit(6, 1, 3); emit(6, 1, 7); emit(7, 3, 0); emit(7, 7, 0);
        emit(3, 6, 6); emit(6, 6, 3); emit(0, 6, 6); emit(3, 0, 0); emit(5, 6, 0); emit(7, 7, 0);
        emit(4, 7, 0); emit(7, 7, 0);
        emit(3, 1, 1); emit(6, 1, 1);
        for (int i = 0; i < 7; i++) emit(7, 0, 1);
        emit(3, 2, 2); emit(0, 2, 1); emit(0, 1, 2); emit(7, 7, 0);
        emit(3, 3, 3); emit(6, 3, 1); emit(7, 1, 3); emit(7, 7, 0);
        emit(3, 4, 4); emit(6, 4, 1);
        for (int i = 0; i < 7; i++) emit(7, 0, 4);
        emit(6, 4, 1); emit(7, 0, 4); emit(7, 7, 0);
        emit(3, 5, 5); emit(7, 2, 2); emit(6, 5, 1); emit(7, 7, 0);
        emit(6, 5, 2); emit(7, 2, 2); emit(7, 4, 3); emit(6, 5, 1); emit(7, 7, 0);
        emit(7, 5, 0); emit(7, 6, 0); emit(7, 3, 4); emit(7, 7, 0); emit(7, 7, 0);
        // Random straight-line programs: no branches or HALT inside the body.
        for (int p = 0; p < RAND_PROGRAMS; p++) begin
            len = $urandom_range(3, 12);
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(0, 7);
                a  = $urandom_range(0, 7);
                if (op == 7) begin
                    case ($urandom_range(0, 3))
                        0:       a = 0;
                        1:       a = 1;
                        2:       a = 5;
                        default: a = 6;
                    endcase
                end
                emit(op, a, $urandom_range(0, 7));
            end
            emit(7, 7, 0);
        end
    endfunction

    task automatic applyStimulus(input int abortAfter);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        checkOutput("reset_done", DONE, 0);
        checkOutput("reset_pc", dut.pc, mResume);
        @(negedge CLK);
        START = 1'b0;
        if (abortAfter > 0) begin
            modelPartial(abortAfter);
            repeat (abortAfter) @(negedge CLK);
            START = 1'b1;
            @(negedge CLK);
            checkOutput("abort_done", DONE, 0);
            checkOutput("abort_pc", dut.pc, mResume);
            @(negedge CLK);
            START = 1'b0;
        end
        expectQ.push_back(runModel());
        launches++;
        wait (checkedCount == launches);
    endtask

    initial begin : monitor
        expect_t e;
        int      cycles;
        int      diffAt;
        forever begin
            wait (launches > checkedCount);
            e      = expectQ.pop_front();
            cycles = 0;
            while (cycles < CYCLE_BUDGET) begin
                @(negedge CLK);
                cycles++;
                if (DONE) break;
            end
            checkOutput("done_latency", cycles, e.cycles);
            checkOutput("halt_pc", dut.pc, e.haltPc);
            checkOutput("zero_flag", dut.zeroFlag, e.zero);
            for (int i = 0; i < 8; i++)
                checkOutput($sformatf("reg_r%0d", i), dut.regFile[i], e.regs[i*8 +: 8]);
            diffAt = -1;
            for (int i = 0; i < 256; i++)
                if (diffAt < 0 && dut.dataMem[i] != e.mem[i*8 +: 8]) diffAt = i;
            checks++;
            if (diffAt >= 0) begin
                failures++;
                $display("[TB] FAIL dmem: word %0d got %0d, expected %0d",
                         diffAt, dut.dataMem[diffAt], e.mem[diffAt*8 +: 8]);
            end
            repeat (3) @(negedge CLK);
            checkOutput("done_hold", DONE, 1);
            checkOutput("pc_hold", dut.pc, e.haltPc);
            checkedCount++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        buildRom();
        for (int i = 0; i < ROM_DEPTH; i++) dut.instrMem[i] = 9'(rom[i]);
        for (int i = 0; i < 8; i++) mRegs[i] = 0;
        for (int i = 0; i < 256; i++) mMem[i] = 0;
        repeat (3) @(negedge CLK);
        checkOutput("powerup_done", DONE, 0);
        for (int p = 0; p < 3; p++) applyStimulus(0);
        applyStimulus(5);
        for (int p = 0; p < 6 + RAND_PROGRAMS; p++) applyStimulus(0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/divvy_cpu_top.md
Name: divvy_cpu_top

Overview:
- Top-level of the course single-cycle 8-bit accumulator-less load/store processor with 9-bit instructions.
- Contents: instruction ROM, 8x8 register file, ALU, 256x8 data memory, program counter.
- START pulse launches the next program in ROM; DONE reports that program has halted.
- Consecutive programs share data memory and registers.

Parameters:
- PC_W, 10, program counter / instruction ROM address width (1024 instructions).
- DATA_W, 8, datapath and register width.
- DMEM_DEPTH, 256, data memory words (addressed by an 8-bit register value).
- IMEM_FILE, "machine_code.txt", $readmemb image loaded into instruction ROM.

Ports:
- CLK  in  1  rising-edge clock, sole clock.
- START  in  1  synchronous active-high reset/launch; held >=1 cycle.
- DONE  out  1  high while the current program is halted.

Behaviour:
- Instruction format: op=i[8:6], a=i[5:3], b=i[2:0]; R[x] are 8-bit registers; Z is a zero flag.
- 000 ADD R[a]=R[a]+R[b]; 001 SUB R[a]=R[a]-R[b]; 010 AND; 011 XOR (all mod 256).
- 100 LW R[a]=M[R[b]]; 101 SW M[R[b]]=R[a].
- 110 ADDI R[a]=R[a]+sext(b), imm range -4..3.
- 111 misc, sub-op in a:
  - 000 SHL R[b]<<=1; 001 SHR R[b]>>=1 (logical).
  - 010 BZ: if Z, PC=LUT[b]; 011 BNZ: if !Z, PC=LUT[b]; 100 JMP: PC=LUT[b].
  - 101/110 NOP; 111 HALT.
- Z update:
  - Updated by ADD, SUB, AND, XOR, ADDI, SHL, SHR: Z = (result == 0).
  - Unchanged by loads, stores, branches and NOP.
- LUT: 8-entry constant table of PC_W-bit absolute branch targets.
- Timing, single cycle:
  - ROM and data-memory reads are combinational.
  - Register file, memory, Z and PC update on the rising edge.
  - One instruction retires per clock; non-branch PC=PC+1, PC wraps modulo 2^PC_W.
- Sync reset (START=1 at an edge):
  - PC<=resume_pc, DONE<=0, halted<=0, Z<=0.
  - Registers and data memory are NOT cleared.
  - resume_pc powers up at 0 (initial value); START never changes it.
- Run: the first instruction executes on the first edge with START=0.
- HALT executes at an edge:
  - halted<=1, DONE<=1, resume_pc<=PC+1.
  - PC holds; no further register or memory writes.
- Halted state: DONE stays 1 until START. START mid-run aborts the program and restarts it at the same resume_pc.
- Power-up (before any START): DONE=0. The core executes only after the first START edge; a run flag is cleared at power-up.
- Result: program k begins at the instruction following the HALT of program k-1.

Decomposition:
- Package divvy_pkg:
  - opcode and misc sub-op enums.
  - width constants.
  - branch-target LUT (localparam array).
  - instruction field extract functions.
- Sub-module divvy_alu: combinational, op/sub-op + two 8-bit operands + imm3 -> 8-bit result and zero flag.
- Register file, data memory and PC remain in the top.

Test Plan:
- Arithmetic: START 2 cycles, then run ADDI R1,3; ADDI R1,3; ADD R2,R1; HALT.
  - DONE rises 4 cycles after START falls.
  - R1=6, R2=6, DONE stays high with PC constant.
- Memory: ADDI R3,2; ADDI R4,-1 (0xFF); SW R4,[R3]; LW R5,[R3]; HALT -> M[2]=0xFF, R5=0xFF.
- Loop: LUT[0]=loop. Run R1=3; loop: ADDI R1,-1; BNZ 0; HALT.
  - Exactly 3 iterations, R1=0, Z=1.
  - DONE asserts 8 cycles after START falls (1 init + 6 loop + HALT).
- Back-to-back:
  - Program 1 halts at address 4 and stores 0x06 to M[0].
  - Second START launches at PC=5; program 2 LW reads 0x06.
  - DONE drops on START and re-asserts at program 2 HALT.
- Reset mid-run: START asserted during loop iteration 2.
  - DONE=0 and PC=resume_pc on that edge.
  - The rerun completes normally.
- Wrap/flags: ADD 0x80+0x80 -> result 0x00, Z=1; SHR of 0x01 -> 0x00, Z=1; SHL 0x81 -> 0x02.
